// File: rtl/qdec_cabac_package.sv
// Shared types and default widths for the CABAC/CTU syntax path.
// Holds the CTU reader FSM encoding and line-buffer default sizes.
package qdec_cabac_package;

  localparam int LB_ADDR_W_DEF = 12;
  localparam int LB_DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } ctuState_e;

endpackage

// File: rtl/qdec_skid_fifo.sv
// Small register-based FIFO carrying a data byte plus a last flag.
// Head is read straight from the storage registers, so outputs are registered.
module qdec_skid_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [DATA_W-1:0] wrData,
  input  logic              wrLast,
  input  logic              rdEn,
  output logic [DATA_W-1:0] rdData,
  output logic              rdLast,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W:0] mem [DEPTH];
  logic [PW-1:0]   wrPtr;
  logic [PW-1:0]   rdPtr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wrEn) begin
        mem[wrPtr] <= {wrLast, wrData};
        wrPtr      <= wrPtr + PW'(1);
      end
      if (rdEn) begin
        rdPtr <= rdPtr + PW'(1);
      end
      case ({wrEn, rdEn})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdData = mem[rdPtr][DATA_W-1:0];
  assign rdLast = mem[rdPtr][DATA_W];
  assign empty  = (count == '0);

endmodule

// File: rtl/qdec_ctu_syntax_reader.sv
// Streams a completed CTU's syntax bytes out of the line buffer
// through a small skid FIFO with a valid/ready/last handshake.
module qdec_ctu_syntax_reader
  import qdec_cabac_package::*;
#(
  parameter int LB_ADDR_W  = LB_ADDR_W_DEF,
  parameter int LB_DATA_W  = LB_DATA_W_DEF,
  parameter int SKID_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ctu_done,
  input  logic [LB_ADDR_W:0]   ctu_len,
  output logic [LB_ADDR_W-1:0] lb_raddr,
  output logic                 lb_re,
  input  logic [LB_DATA_W-1:0] lb_dout,
  output logic [LB_DATA_W-1:0] syn_data,
  output logic                 syn_vld,
  input  logic                 syn_rdy,
  output logic                 syn_last,
  output logic                 busy,
  output logic                 ovf_err
);

  localparam int CW  = $clog2(SKID_DEPTH) + 1;
  localparam int AW1 = LB_ADDR_W + 1;

  ctuState_e state;
  ctuState_e nextState;

  logic [LB_ADDR_W:0] addr;
  logic [LB_ADDR_W:0] lenReg;
  logic               rdPending;
  logic               pendLast;
  logic               pop;
  logic               isLast;
  logic               start;
  logic               fifoEmpty;
  logic [CW-1:0]      fifoCount;
  logic [CW:0]        occ;

  assign pop      = syn_vld & syn_rdy;
  assign isLast   = (addr == lenReg - AW1'(1));
  assign start    = (state == IDLE) && ctu_done && (ctu_len != '0);
  assign lb_raddr = addr[LB_ADDR_W-1:0];
  assign syn_vld  = ~fifoEmpty;

  // A slot freed by this cycle's pop is reusable now; keeps 1 byte/cycle.
  assign occ = {1'b0, fifoCount} + {CW'(0), rdPending} - {CW'(0), pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (start) nextState = READ;
      READ:  if (lb_re && isLast) nextState = DRAIN;
      DRAIN: if (pop && syn_last) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    lb_re = 1'b0;
    busy  = (state != IDLE);
    if (state == READ) begin
      lb_re = (occ < (CW+1)'(SKID_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      lenReg    <= '0;
      rdPending <= 1'b0;
      pendLast  <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      if (start) begin
        lenReg <= ctu_len;
        addr   <= '0;
      end else if (lb_re) begin
        addr <= addr + AW1'(1);
      end
      rdPending <= lb_re;
      pendLast  <= lb_re & isLast;
      if (ctu_done && (state != IDLE)) begin
        ovf_err <= 1'b1;
      end
    end
  end

  qdec_skid_fifo #(
    .DATA_W (LB_DATA_W),
    .DEPTH  (SKID_DEPTH)
  ) uSkid (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (rdPending),
    .wrData (lb_dout),
    .wrLast (pendLast),
    .rdEn   (pop),
    .rdData (syn_data),
    .rdLast (syn_last),
    .empty  (fifoEmpty),
    .count  (fifoCount)
  );

endmodule

// File: tb/tb_qdec_ctu_syntax_reader.sv
// Bench for the CTU syntax reader: line-buffer model, stream scoreboard,
// vector table, random transfers and hand-built corner sequences.
module tb_qdec_ctu_syntax_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctu_done;
  logic [12:0] ctu_len;
  logic [11:0] lb_raddr;
  logic        lb_re;
  logic [7:0]  lb_dout = 8'hEE;
  logic [7:0]  syn_data;
  logic        syn_vld;
  logic        syn_rdy;
  logic        syn_last;
  logic        busy;
  logic        ovf_err;

  qdec_ctu_syntax_reader dut (
    .clk      (clk),
    .rst      (rst),
    .ctu_done (ctu_done),
    .ctu_len  (ctu_len),
    .lb_raddr (lb_raddr),
    .lb_re    (lb_re),
    .lb_dout  (lb_dout),
    .syn_data (syn_data),
    .syn_vld  (syn_vld),
    .syn_rdy  (syn_rdy),
    .syn_last (syn_last),
    .busy     (busy),
    .ovf_err  (ovf_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] lbMem [4096];
  int  curLen = 0;
  int  nextAddr = 0;
  int  accIdx = 0;
  int  firstCyc = 0;
  int  lastCyc = 0;
  bit  monOn = 1'b0;
  bit  holdPend = 1'b0;
  logic [7:0] holdData;
  logic       holdLast;
  bit  rdyRand = 1'b0;
  logic rdyFixed = 1'b1;

  typedef struct {
    int len;
    bit randRdy;
    bit incPat;
    int expBytes;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line buffer: data valid exactly one cycle after lb_re, junk otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    lb_dout <= lb_re ? lbMem[lb_raddr] : 8'hEE;
  end

  initial begin
    syn_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      syn_rdy = rdyRand ? 1'($urandom_range(0, 1)) : rdyFixed;
    end
  end

  // Scoreboard: in-order address stream and byte stream from lbMem.
  always @(negedge clk) begin
    if (monOn) begin
      if (lb_re || syn_vld) begin
        chk("outstanding_le2", int'((nextAddr - accIdx) <= 2), 1);
      end
      if (lb_re) begin
        chk("re_in_range", int'(nextAddr < curLen), 1);
        chk("raddr", int'(lb_raddr), nextAddr % 4096);
        nextAddr++;
      end
      if (holdPend) begin
        chk("hold_vld", int'(syn_vld), 1);
        chk("hold_data", int'(syn_data), int'(holdData));
        chk("hold_last", int'(syn_last), int'(holdLast));
      end
      if (syn_vld && syn_rdy) begin
        chk("byte_in_range", int'(accIdx < curLen), 1);
        chk("syn_data", int'(syn_data), int'(lbMem[accIdx % 4096]));
        chk("syn_last", int'(syn_last), int'(accIdx == curLen - 1));
        if (accIdx == 0) firstCyc = cyc;
        lastCyc = cyc;
        accIdx++;
      end
      holdPend = syn_vld && !syn_rdy;
      holdData = syn_data;
      holdLast = syn_last;
    end
  end

  task automatic chkResetVals(input string tag);
    chk({tag, "_lb_re"}, int'(lb_re), 0);
    chk({tag, "_lb_raddr"}, int'(lb_raddr), 0);
    chk({tag, "_syn_vld"}, int'(syn_vld), 0);
    chk({tag, "_syn_data"}, int'(syn_data), 0);
    chk({tag, "_syn_last"}, int'(syn_last), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ovf_err"}, int'(ovf_err), 0);
  endtask

  task automatic fill(input int len, input bit incPat);
    for (int i = 0; i < len; i++) begin
      lbMem[i] = incPat ? 8'((i + 16) & 255) : 8'($urandom);
    end
    curLen = len;
    nextAddr = 0;
    accIdx = 0;
    holdPend = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    monOn = 1'b0;
    rst = 1'b1;
    ctu_done = 1'b0;
    @(posedge clk);
    #1;
    chkResetVals("rst");
    rst = 1'b0;
    fill(0, 1'b1);
    monOn = 1'b1;
  endtask

  task automatic waitDone(input int len, input string tag);
    int t = 0;
    int lim = len * 8 + 100;
    while (accIdx < len && t < lim) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk({tag, "_no_timeout"}, int'(t < lim), 1);
  endtask

  task automatic doXfer(input int len, input bit randRdy, input bit incPat,
                        input int expBytes);
    fill(len, incPat);
    rdyRand = randRdy;
    rdyFixed = 1'b1;
    @(posedge clk);
    #1;
    ctu_done = 1'b1;
    ctu_len = 13'(len);
    @(posedge clk);
    #1;
    ctu_done = 1'b0;
    chk("busy_after_done", int'(busy), int'(len > 0));
    if (len > 0) begin
      @(posedge clk);
      #1;
      chk("vld_early", int'(syn_vld), 0);
      @(posedge clk);
      #1;
      chk("first_vld_lat3", int'(syn_vld), 1);
    end
    waitDone(len, "xfer");
    chk("bytes", accIdx, expBytes);
    chk("reads", nextAddr, len);
    chk("busy_fall", int'(busy), 0);
    if (!randRdy && len > 1) begin
      chk("throughput", lastCyc - firstCyc, len - 1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("vld_idle", int'(syn_vld), 0);
    chk("bytes_final", accIdx, expBytes);
    rdyRand = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{len: 5,    randRdy: 1'b0, incPat: 1'b1, expBytes: 5};
    vecs[1] = '{len: 16,   randRdy: 1'b1, incPat: 1'b0, expBytes: 16};
    vecs[2] = '{len: 0,    randRdy: 1'b0, incPat: 1'b1, expBytes: 0};
    vecs[3] = '{len: 1,    randRdy: 1'b0, incPat: 1'b1, expBytes: 1};
    vecs[4] = '{len: 3,    randRdy: 1'b1, incPat: 1'b1, expBytes: 3};
    vecs[5] = '{len: 4096, randRdy: 1'b0, incPat: 1'b0, expBytes: 4096};
    vecs[6] = '{len: 7,    randRdy: 1'b1, incPat: 1'b0, expBytes: 7};

    rst = 1'b1;
    ctu_done = 1'b0;
    ctu_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chkResetVals("init");
    rst = 1'b0;
    monOn = 1'b1;

    for (int v = 0; v < 7; v++) begin
      doXfer(vecs[v].len, vecs[v].randRdy, vecs[v].incPat, vecs[v].expBytes);
    end

    for (int k = 0; k < 6; k++) begin
      int len = $urandom_range(1, 40);
      doXfer(len, 1'b1, 1'b0, len);
    end

    // Overflow: second ctu_done during a len=8 transfer is dropped.
    fill(8, 1'b1);
    rdyFixed = 1'b1;
    @(posedge clk);
    #1;
    ctu_done = 1'b1;
    ctu_len = 13'd8;
    @(posedge clk);
    #1;
    ctu_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_pre", int'(ovf_err), 0);
    ctu_done = 1'b1;
    ctu_len = 13'd3;
    @(posedge clk);
    #1;
    ctu_done = 1'b0;
    chk("ovf_set", int'(ovf_err), 1);
    waitDone(8, "ovf");
    repeat (4) @(posedge clk);
    #1;
    chk("ovf_bytes", accIdx, 8);
    chk("ovf_reads", nextAddr, 8);
    chk("ovf_sticky", int'(ovf_err), 1);
    doReset();

    // ctu_done in the very cycle the last byte is accepted.
    fill(2, 1'b0);
    rdyFixed = 1'b0;
    @(posedge clk);
    #1;
    ctu_done = 1'b1;
    ctu_len = 13'd2;
    @(posedge clk);
    #1;
    ctu_done = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rdyFixed = 1'b1;
    @(posedge clk);
    #1;
    rdyFixed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("edge_one_acc", accIdx, 1);
    chk("edge_busy_pre", int'(busy), 1);
    rdyFixed = 1'b1;
    ctu_done = 1'b1;
    ctu_len = 13'd3;
    @(posedge clk);
    #1;
    ctu_done = 1'b0;
    chk("edge_bytes", accIdx, 2);
    chk("edge_busy", int'(busy), 0);
    chk("edge_ovf", int'(ovf_err), 1);
    repeat (6) @(posedge clk);
    #1;
    chk("edge_no_restart", int'(busy), 0);
    chk("edge_reads", nextAddr, 2);
    doReset();

    // Reset mid-transfer at byte 3 of 10, then a clean len=2 transfer.
    fill(10, 1'b0);
    rdyFixed = 1'b1;
    @(posedge clk);
    #1;
    ctu_done = 1'b1;
    ctu_len = 13'd10;
    @(posedge clk);
    #1;
    ctu_done = 1'b0;
    waitDone(3, "midrst");
    monOn = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chkResetVals("midrst");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_discard_vld", int'(syn_vld), 0);
    chk("midrst_idle", int'(busy), 0);
    fill(0, 1'b1);
    monOn = 1'b1;
    doXfer(2, 1'b0, 1'b1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
